// File: rtl/operand_stage_if.sv
// ----------------------------------------------------------------------------
// operand_stage_if
// ID/EX pipeline-register bus between the operand stage and the execute stage.
//   valid    : ID/EX register holds an instruction
//   ready    : EX accepts the held instruction this cycle
//   pc       : instruction PC
//   rs1_val  : resolved first operand
//   rs2_val  : resolved second operand
//   rd       : destination index
//   rd_wen   : instruction writes rd
//   is_load  : instruction is a load
// master = operand stage (producer), slave = execute stage (consumer).
// ----------------------------------------------------------------------------
interface operand_stage_if #(
    parameter int XLEN = 64
);
    logic            valid;
    logic            ready;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [4:0]      rd;
    logic            rd_wen;
    logic            is_load;

    modport master (
        output valid, pc, rs1_val, rs2_val, rd, rd_wen, is_load,
        input  ready
    );

    modport slave (
        input  valid, pc, rs1_val, rs2_val, rd, rd_wen, is_load,
        output ready
    );
endinterface

// File: rtl/operand_stage.sv
// ----------------------------------------------------------------------------
// operand_stage
// Decode-to-execute boundary of the RV64 pipeline. Drives the regfile read
// indices, forwards results from EX/MEM/WB over stale regfile data, stalls on
// load-use hazards and captures resolved operands into the ID/EX register
// behind a valid/ready handshake. flush kills the register for branch redirect.
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   in_*                      : decoded instruction from ID with in_ready
//   index_rs1/2, gpr_data_rs1/2 : combinational regfile read port
//   ex_*, mem_*, wb_*         : bypass sources (EX beats MEM beats WB)
//   flush                     : kill ID/EX contents, refuse capture
//   id_ex                     : ID/EX register bus to EX (master side)
// ----------------------------------------------------------------------------
module operand_stage #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [4:0]      in_rs1,
    input  logic [4:0]      in_rs2,
    input  logic            in_uses_rs1,
    input  logic            in_uses_rs2,
    input  logic [4:0]      in_rd,
    input  logic            in_rd_wen,
    input  logic            in_is_load,
    output logic [4:0]      index_rs1,
    output logic [4:0]      index_rs2,
    input  logic [XLEN-1:0] gpr_data_rs1,
    input  logic [XLEN-1:0] gpr_data_rs2,
    input  logic            ex_valid,
    input  logic            ex_rd_wen,
    input  logic            ex_is_load,
    input  logic [4:0]      ex_rd,
    input  logic [XLEN-1:0] ex_result,
    input  logic            mem_valid,
    input  logic            mem_rd_wen,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_result,
    input  logic            wb_wen,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    operand_stage_if.master id_ex
);

    logic [XLEN-1:0] rs1_val_s;
    logic [XLEN-1:0] rs2_val_s;
    logic            stall_s;
    logic            capture_s;

    logic            valid_r;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] rs1_val_r;
    logic [XLEN-1:0] rs2_val_r;
    logic [4:0]      rd_r;
    logic            rd_wen_r;
    logic            is_load_r;

    // Youngest producer wins. The WB write lands in the regfile only on the
    // next edge, so the regfile read data is stale for wb_rd this cycle.
    function automatic logic [XLEN-1:0] resolve(input logic [4:0]      src,
                                                input logic [XLEN-1:0] gpr_val);
        logic [XLEN-1:0] val;
        if (src == 5'd0) begin
            val = {XLEN{1'b0}};
        end else if (ex_valid && ex_rd_wen && (ex_rd == src)) begin
            val = ex_result;
        end else if (mem_valid && mem_rd_wen && (mem_rd == src)) begin
            val = mem_result;
        end else if (wb_wen && (wb_rd == src)) begin
            val = wb_data;
        end else begin
            val = gpr_val;
        end
        return val;
    endfunction

    assign index_rs1 = in_rs1;
    assign index_rs2 = in_rs2;

    // Operand bypass, load-use detection and ID handshake.
    always_comb begin
        rs1_val_s = resolve(in_rs1, gpr_data_rs1);
        rs2_val_s = resolve(in_rs2, gpr_data_rs2);
        // A load in EX has no data yet; x0 writes are never hazards.
        if (ex_valid && ex_is_load && ex_rd_wen && (ex_rd != 5'd0)) begin
            stall_s = (in_uses_rs1 && (in_rs1 == ex_rd)) ||
                      (in_uses_rs2 && (in_rs2 == ex_rd));
        end else begin
            stall_s = 1'b0;
        end
        in_ready  = !flush && !stall_s && (!valid_r || id_ex.ready);
        capture_s = in_valid && in_ready;
    end

    // ID/EX pipeline register; flush has priority (in_ready is already low).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r   <= 1'b0;
            pc_r      <= {XLEN{1'b0}};
            rs1_val_r <= {XLEN{1'b0}};
            rs2_val_r <= {XLEN{1'b0}};
            rd_r      <= 5'd0;
            rd_wen_r  <= 1'b0;
            is_load_r <= 1'b0;
        end else if (flush) begin
            valid_r <= 1'b0;
        end else if (capture_s) begin
            valid_r   <= 1'b1;
            pc_r      <= in_pc;
            rs1_val_r <= rs1_val_s;
            rs2_val_r <= rs2_val_s;
            rd_r      <= in_rd;
            rd_wen_r  <= in_rd_wen;
            is_load_r <= in_is_load;
        end else if (!valid_r || id_ex.ready) begin
            // Bubble: consumed or empty with nothing new (covers stall).
            valid_r <= 1'b0;
        end else begin
            // Backpressure: hold everything.
            valid_r <= valid_r;
        end
    end

    assign id_ex.valid   = valid_r;
    assign id_ex.pc      = pc_r;
    assign id_ex.rs1_val = rs1_val_r;
    assign id_ex.rs2_val = rs2_val_r;
    assign id_ex.rd      = rd_r;
    assign id_ex.rd_wen  = rd_wen_r;
    assign id_ex.is_load = is_load_r;

endmodule

// File: tb/tb_operand_stage.sv
// ----------------------------------------------------------------------------
// tb_operand_stage
// Self-checking bench for operand_stage: directed scenarios plus randomized
// traffic compared against a behavioural model of the ID/EX register.
// ----------------------------------------------------------------------------
module tb_operand_stage;
    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid, in_ready;
    logic [XLEN-1:0] in_pc;
    logic [4:0]      in_rs1, in_rs2, in_rd;
    logic            in_uses_rs1, in_uses_rs2, in_rd_wen, in_is_load;
    logic [4:0]      index_rs1, index_rs2;
    logic [XLEN-1:0] gpr_data_rs1, gpr_data_rs2;
    logic            ex_valid, ex_rd_wen, ex_is_load;
    logic [4:0]      ex_rd;
    logic [XLEN-1:0] ex_result;
    logic            mem_valid, mem_rd_wen;
    logic [4:0]      mem_rd;
    logic [XLEN-1:0] mem_result;
    logic            wb_wen;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            flush;

    operand_stage_if #(.XLEN(XLEN)) bus ();

    operand_stage #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_uses_rs1(in_uses_rs1), .in_uses_rs2(in_uses_rs2),
        .in_rd(in_rd), .in_rd_wen(in_rd_wen), .in_is_load(in_is_load),
        .index_rs1(index_rs1), .index_rs2(index_rs2),
        .gpr_data_rs1(gpr_data_rs1), .gpr_data_rs2(gpr_data_rs2),
        .ex_valid(ex_valid), .ex_rd_wen(ex_rd_wen), .ex_is_load(ex_is_load),
        .ex_rd(ex_rd), .ex_result(ex_result),
        .mem_valid(mem_valid), .mem_rd_wen(mem_rd_wen), .mem_rd(mem_rd),
        .mem_result(mem_result),
        .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush),
        .id_ex(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference ID/EX contents
    logic            m_valid;
    logic [XLEN-1:0] m_pc, m_rs1, m_rs2;
    logic [4:0]      m_rd;
    logic            m_rd_wen, m_is_load;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Producer list in priority order; first live writer of src supplies it.
    function automatic logic [XLEN-1:0] model_operand(input logic [4:0] src, input logic [XLEN-1:0] gpr);
        logic            live [3];
        logic [4:0]      dst  [3];
        logic [XLEN-1:0] dat  [3];
        live[0] = ex_valid && ex_rd_wen;   dst[0] = ex_rd;  dat[0] = ex_result;
        live[1] = mem_valid && mem_rd_wen; dst[1] = mem_rd; dat[1] = mem_result;
        live[2] = wb_wen;                  dst[2] = wb_rd;  dat[2] = wb_data;
        if (src == 5'd0) return '0;
        for (int i = 0; i < 3; i++)
            if (live[i] && dst[i] == src) return dat[i];
        return gpr;
    endfunction

    function automatic logic model_stall();
        logic [4:0] reads [$];
        if (in_uses_rs1) reads.push_back(in_rs1);
        if (in_uses_rs2) reads.push_back(in_rs2);
        if (!(ex_valid && ex_is_load && ex_rd_wen) || ex_rd == 5'd0) return 1'b0;
        foreach (reads[i]) if (reads[i] == ex_rd) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_pc = '0; m_rs1 = '0; m_rs2 = '0;
        m_rd = 5'd0; m_rd_wen = 1'b0; m_is_load = 1'b0;
    endtask

    task automatic check_outputs(input string pfx);
        check({pfx, "_out_valid"},   {63'd0, bus.valid},   {63'd0, m_valid});
        check({pfx, "_out_pc"},      bus.pc,               m_pc);
        check({pfx, "_out_rs1_val"}, bus.rs1_val,          m_rs1);
        check({pfx, "_out_rs2_val"}, bus.rs2_val,          m_rs2);
        check({pfx, "_out_rd"},      {59'd0, bus.rd},      {59'd0, m_rd});
        check({pfx, "_out_rd_wen"},  {63'd0, bus.rd_wen},  {63'd0, m_rd_wen});
        check({pfx, "_out_is_load"}, {63'd0, bus.is_load}, {63'd0, m_is_load});
    endtask

    task automatic idle();
        in_valid = 1'b0; in_pc = '0; in_rs1 = 5'd0; in_rs2 = 5'd0;
        in_uses_rs1 = 1'b0; in_uses_rs2 = 1'b0; in_rd = 5'd0;
        in_rd_wen = 1'b0; in_is_load = 1'b0;
        gpr_data_rs1 = '0; gpr_data_rs2 = '0;
        ex_valid = 1'b0; ex_rd_wen = 1'b0; ex_is_load = 1'b0; ex_rd = 5'd0; ex_result = '0;
        mem_valid = 1'b0; mem_rd_wen = 1'b0; mem_rd = 5'd0; mem_result = '0;
        wb_wen = 1'b0; wb_rd = 5'd0; wb_data = '0;
        flush = 1'b0; bus.ready = 1'b1;
    endtask

    // One clock: check combinational outputs, predict the edge, check registers.
    task automatic step(input string pfx);
        logic rdy;
        #1;
        rdy = !flush && !model_stall() && (!m_valid || bus.ready);
        check({pfx, "_in_ready"},  {63'd0, in_ready},  {63'd0, rdy});
        check({pfx, "_index_rs1"}, {59'd0, index_rs1}, {59'd0, in_rs1});
        check({pfx, "_index_rs2"}, {59'd0, index_rs2}, {59'd0, in_rs2});
        @(posedge clk);
        if (flush) m_valid = 1'b0;
        else if (in_valid && rdy) begin
            m_valid = 1'b1; m_pc = in_pc;
            m_rs1 = model_operand(in_rs1, gpr_data_rs1);
            m_rs2 = model_operand(in_rs2, gpr_data_rs2);
            m_rd = in_rd; m_rd_wen = in_rd_wen; m_is_load = in_is_load;
        end else if (!m_valid || bus.ready) m_valid = 1'b0;
        #1;
        check_outputs(pfx);
    endtask

    function automatic logic [XLEN-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic randomize_inputs();
        in_valid = ($urandom_range(0, 3) != 0);
        in_pc = rnd64();
        in_rs1 = 5'($urandom_range(0, 7)); in_rs2 = 5'($urandom_range(0, 7));
        in_uses_rs1 = 1'($urandom); in_uses_rs2 = 1'($urandom);
        in_rd = 5'($urandom); in_rd_wen = 1'($urandom); in_is_load = 1'($urandom);
        gpr_data_rs1 = rnd64(); gpr_data_rs2 = rnd64();
        ex_valid = 1'($urandom); ex_rd_wen = 1'($urandom);
        ex_is_load = ($urandom_range(0, 3) == 0);
        ex_rd = 5'($urandom_range(0, 7)); ex_result = rnd64();
        mem_valid = 1'($urandom); mem_rd_wen = 1'($urandom);
        mem_rd = 5'($urandom_range(0, 7)); mem_result = rnd64();
        wb_wen = 1'($urandom); wb_rd = 5'($urandom_range(0, 7)); wb_data = rnd64();
        flush = ($urandom_range(0, 9) == 0);
        bus.ready = ($urandom_range(0, 3) != 0);
    endtask

    logic [XLEN-1:0] held_pc;

    initial begin
        idle();
        rst = 1'b1;
        model_reset();
        #2;
        check_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Bypass priority chain on x5
        in_valid = 1'b1; in_pc = 64'h1000; in_rs1 = 5'd5; in_uses_rs1 = 1'b1;
        in_rd = 5'd9; in_rd_wen = 1'b1;
        ex_valid = 1'b1; ex_rd_wen = 1'b1; ex_rd = 5'd5; ex_result = 64'h11;
        mem_valid = 1'b1; mem_rd_wen = 1'b1; mem_rd = 5'd5; mem_result = 64'h22;
        wb_wen = 1'b1; wb_rd = 5'd5; wb_data = 64'h33;
        gpr_data_rs1 = 64'h44;
        step("byp_ex");  check("byp_ex_val",  bus.rs1_val, 64'h11);
        ex_valid = 1'b0;
        step("byp_mem"); check("byp_mem_val", bus.rs1_val, 64'h22);
        mem_valid = 1'b0;
        step("byp_wb");  check("byp_wb_val",  bus.rs1_val, 64'h33);
        wb_wen = 1'b0;
        step("byp_gpr"); check("byp_gpr_val", bus.rs1_val, 64'h44);

        // x0 never forwarded
        in_rs1 = 5'd0; gpr_data_rs1 = 64'h55;
        ex_valid = 1'b1; ex_rd_wen = 1'b1; ex_rd = 5'd0; ex_result = 64'hDEAD;
        step("x0"); check("x0_val", bus.rs1_val, 64'h0);

        // Load-use stall, then MEM bypass of the load data
        idle();
        in_valid = 1'b1; in_pc = 64'h2000; in_rs2 = 5'd7; in_uses_rs2 = 1'b1;
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd_wen = 1'b1; ex_rd = 5'd7;
        step("lu_stall");
        check("lu_bubble", {63'd0, bus.valid}, 64'd0);
        ex_valid = 1'b0; mem_valid = 1'b1; mem_rd_wen = 1'b1; mem_rd = 5'd7;
        mem_result = 64'h99;
        step("lu_cap"); check("lu_val", bus.rs2_val, 64'h99);
        // Same hazard shape but rs2 not read: no stall
        idle();
        in_valid = 1'b1; in_pc = 64'h2004; in_rs2 = 5'd7; in_uses_rs2 = 1'b0;
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd_wen = 1'b1; ex_rd = 5'd7;
        step("lu_unused"); check("lu_unused_cap", bus.pc, 64'h2004);

        // Backpressure for 3 cycles then release
        idle();
        in_valid = 1'b1; in_pc = 64'h3000;
        step("bp_load");
        held_pc = in_pc;
        bus.ready = 1'b0; in_pc = 64'h3004;
        for (int i = 0; i < 3; i++) begin
            step("bp_hold");
            check("bp_hold_pc", bus.pc, held_pc);
        end
        bus.ready = 1'b1;
        step("bp_release"); check("bp_release_pc", bus.pc, 64'h3004);

        // Flush while stalled with a held valid instruction
        bus.ready = 1'b0;
        in_pc = 64'h4000; in_rs1 = 5'd3; in_uses_rs1 = 1'b1;
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd_wen = 1'b1; ex_rd = 5'd3;
        flush = 1'b1;
        step("flush");
        check("flush_pc_kept", bus.pc, 64'h3004);
        idle();

        // Randomized traffic with occasional mid-cycle resets
        for (int n = 0; n < 400; n++) begin
            randomize_inputs();
            step("rnd");
            if ($urandom_range(0, 49) == 0) begin
                #2 rst = 1'b1;
                model_reset();
                #1 check_outputs("rst_mid");
                rst = 1'b0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
